// File: rtl/fetch_issue_buffer_if.sv
// Fetch/issue handshake bundle for fetch_issue_buffer.
// The slave modport is the buffer side; the master modport is the fetch/issue side.
interface fetch_issue_buffer_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned IW      = 16,
    parameter int unsigned AW      = 16
) ();
    logic                             fetch_valid;
    logic                             fetch_ready;
    logic [AW-1:0]                    fetch_pc;
    logic [FETCH_W*IW-1:0]            fetch_inst;
    logic [FETCH_W-1:0]               fetch_mask;
    logic [ISSUE_W-1:0]               issue_valid;
    logic [ISSUE_W*IW-1:0]            issue_inst;
    logic [ISSUE_W*AW-1:0]            issue_pc;
    logic [ISSUE_W*AW-1:0]            issue_pc_plus1;
    logic [$clog2(ISSUE_W+1)-1:0]     issue_take;
    logic                             flush;
    logic [$clog2(DEPTH+1)-1:0]       count;

    modport master (
        output fetch_valid, fetch_pc, fetch_inst, fetch_mask, issue_take, flush,
        input  fetch_ready, issue_valid, issue_inst, issue_pc, issue_pc_plus1, count
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_inst, fetch_mask, issue_take, flush,
        output fetch_ready, issue_valid, issue_inst, issue_pc, issue_pc_plus1, count
    );
endinterface

// File: rtl/fetch_issue_buffer.sv
// Circular fetch-to-issue instruction buffer with compacting multi-lane write and multi-slot issue.
// Optional FIB_PERF_COUNTERS_EN adds saturating stall_cnt / empty_cnt outputs.
module fetch_issue_buffer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned IW      = 16,
    parameter int unsigned AW      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    fetch_issue_buffer_if.slave  bus
`ifdef FIB_PERF_COUNTERS_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          empty_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - FETCH_W);

    logic [IW-1:0]    mem_inst [DEPTH];
    logic [AW-1:0]    mem_pc   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;

    logic             wr_fire;
    logic [CNT_W-1:0] ofs;
    logic [CNT_W-1:0] n_wr;
    logic [CNT_W-1:0] n_acc;
    logic [CNT_W-1:0] take_ext;
    logic [CNT_W-1:0] take_cl;
    logic [PTR_W-1:0] wr_slot [FETCH_W];

    assign bus.count       = count_q;
    // Ready depends only on registered occupancy, never on same-cycle take/flush.
    assign bus.fetch_ready = (count_q <= READY_LIMIT);
    assign wr_fire         = bus.fetch_valid && bus.fetch_ready && !bus.flush;

    assign take_ext = CNT_W'(bus.issue_take);
    assign take_cl  = (take_ext > count_q) ? count_q : take_ext;
    assign n_acc    = wr_fire ? n_wr : '0;

    // Masked-off lanes consume no slot: each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        ofs = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            wr_slot[i] = tail + PTR_W'(ofs);
            if (bus.fetch_mask[i]) begin
                ofs = ofs + CNT_W'(1);
            end
        end
        n_wr = ofs;
    end

    always_ff @(posedge clock) begin
        if (wr_fire && !reset) begin
            for (int unsigned i = 0; i < FETCH_W; i++) begin
                if (bus.fetch_mask[i]) begin
                    mem_inst[wr_slot[i]] <= bus.fetch_inst[i*IW +: IW];
                    mem_pc[wr_slot[i]]   <= bus.fetch_pc + AW'(i);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            tail    <= tail + PTR_W'(n_acc);
            head    <= head + PTR_W'(take_cl);
            count_q <= count_q + n_acc - take_cl;
        end
    end

    always_comb begin
        bus.issue_valid    = '0;
        bus.issue_inst     = '0;
        bus.issue_pc       = '0;
        bus.issue_pc_plus1 = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            if (count_q > CNT_W'(k)) begin
                bus.issue_valid[k]             = 1'b1;
                bus.issue_inst[k*IW +: IW]     = mem_inst[head + PTR_W'(k)];
                bus.issue_pc[k*AW +: AW]       = mem_pc[head + PTR_W'(k)];
                bus.issue_pc_plus1[k*AW +: AW] = mem_pc[head + PTR_W'(k)] + AW'(1);
            end
        end
    end

`ifdef FIB_PERF_COUNTERS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            empty_cnt <= '0;
        end else begin
            if (bus.fetch_valid && !bus.fetch_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (count_q == '0 && empty_cnt != '1) begin
                empty_cnt <= empty_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
